// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe -- parametrised three-stage floating-point multiplier.
//
// Multiplies two IEEE-754-style operands {sign, biased exponent, fraction}
// with round-to-nearest-even, flush-to-zero for denormal inputs and results,
// and canonical NaN output. A tag travels alongside every operation.
//
// Pipeline: S1 unpack + significand multiply, S2 normalise + round,
// S3 special-case resolution + pack into the output register.
// Whole pipeline holds while the output is valid and not taken.
//
// Parameters:
//   EXP_W   exponent field width (>= 3)
//   FRAC_W  stored fraction width (>= 2)
//   TAG_W   opaque tag width (>= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   block accepts operands this cycle (low only while stalled)
//   in_x/in_y  operands, 1+EXP_W+FRAC_W bits each
//   in_tag     tag returned unchanged with the result
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_z      product
//   out_tag    tag of the product
//   out_flags  {invalid, overflow, underflow, inexact}
//              (only when FP_MUL_PIPE_FLAGS_EN is defined)

module fp_mul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     in_x,
  input  logic [EXP_W+FRAC_W:0]     in_y,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_z,
  output logic [TAG_W-1:0]          out_tag
`ifdef FP_MUL_PIPE_FLAGS_EN
  ,
  output logic [3:0]                out_flags
`endif
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int PW = 2 * FRAC_W + 2;
  localparam int EW = EXP_W + 2;

  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  // Handshake: the whole pipe freezes only when the output register is full
  // and not being taken, so in_ready never depends on in_valid.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------- S1
  logic                x_sign, y_sign;
  logic [EXP_W-1:0]    x_exp, y_exp;
  logic [FRAC_W-1:0]   x_frac, y_frac;
  logic                x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic [PW-1:0]       sig_prod;
  logic signed [EW-1:0] exp_sum;

  assign {x_sign, x_exp, x_frac} = in_x;
  assign {y_sign, y_exp, y_frac} = in_y;

  // bexp 0 covers both true zero and denormals, which are flushed to zero.
  assign x_zero = (x_exp == '0);
  assign y_zero = (y_exp == '0);
  assign x_inf  = (&x_exp) && (x_frac == '0);
  assign y_inf  = (&y_exp) && (y_frac == '0);
  assign x_nan  = (&x_exp) && (x_frac != '0);
  assign y_nan  = (&y_exp) && (y_frac != '0);

  assign sig_prod = PW'({1'b1, x_frac}) * PW'({1'b1, y_frac});

  // Two extra bits keep the biased sum signed and free of wrap-around for
  // every pair of input exponents, specials included.
  assign exp_sum = $signed({2'b00, x_exp}) + $signed({2'b00, y_exp}) - BIAS;

  logic                 s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [PW-1:0]        s1_prod;
  logic signed [EW-1:0] s1_exp;
  logic [TAG_W-1:0]     s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_prod  <= '0;
      s1_exp   <= '0;
      s1_tag   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_sign  <= x_sign ^ y_sign;
      s1_nan   <= x_nan | y_nan | (x_zero & y_inf) | (x_inf & y_zero);
      s1_inf   <= x_inf | y_inf;
      s1_zero  <= x_zero | y_zero;
      s1_prod  <= sig_prod;
      s1_exp   <= exp_sum;
      s1_tag   <= in_tag;
    end
  end

  // ---------------------------------------------------------------- S2
  logic [PW-2:0]        n_mant, d_mant;
  logic                 n_stk, d_stk;
  logic signed [EW-1:0] n_exp, r_exp;
  logic [FRAC_W:0]      keep;
  logic                 guard, sticky, round_up;
  logic [FRAC_W+1:0]    rounded;
  logic [FRAC_W-1:0]    r_frac;

  // Both significands are normalised, so the product leading one sits at
  // bit PW-1 or PW-2; after this step it is always at PW-2. A non-positive
  // exponent takes one more right shift, which keeps the rounded value below
  // the hidden-bit position so such results end up flushed to zero.
  always_comb begin
    n_mant = s1_prod[PW-2:0];
    n_stk  = 1'b0;
    n_exp  = s1_exp;
    if (s1_prod[PW-1]) begin
      n_mant = s1_prod[PW-1:1];
      n_stk  = s1_prod[0];
      n_exp  = s1_exp + EXP_ONE;
    end

    d_mant = n_mant;
    d_stk  = n_stk;
    if (n_exp <= EXP_ZERO) begin
      d_mant = {1'b0, n_mant[PW-2:1]};
      d_stk  = n_stk | n_mant[0];
    end

    keep     = d_mant[PW-2:FRAC_W];
    guard    = d_mant[FRAC_W-1];
    sticky   = d_stk | (|d_mant[FRAC_W-2:0]);
    round_up = guard & (sticky | keep[0]);
    rounded  = {1'b0, keep} + {{(FRAC_W+1){1'b0}}, round_up};

    // A carry out of the significand leaves 10...0, so the fraction is the
    // next-higher slice and the exponent grows by one.
    r_frac = rounded[FRAC_W+1] ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
    r_exp  = n_exp + (rounded[FRAC_W+1] ? EXP_ONE : EXP_ZERO);
  end

  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [FRAC_W-1:0]    s2_frac;
  logic signed [EW-1:0] s2_exp;
  logic [TAG_W-1:0]     s2_tag;
`ifdef FP_MUL_PIPE_FLAGS_EN
  logic                 s2_inexact;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_zero  <= 1'b0;
      s2_frac  <= '0;
      s2_exp   <= '0;
      s2_tag   <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_zero  <= s1_zero;
      s2_frac  <= r_frac;
      s2_exp   <= r_exp;
      s2_tag   <= s1_tag;
    end
  end

`ifdef FP_MUL_PIPE_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_inexact <= 1'b0;
    end else if (!stall) begin
      s2_inexact <= guard | sticky;
    end
  end
`endif

  // ---------------------------------------------------------------- S3
  logic         is_uf, is_of;
  logic [W-1:0] res_z;

  assign is_uf = (s2_exp <= EXP_ZERO);
  assign is_of = (s2_exp >= EXP_MAX);

  // Operand specials take priority over range checks on the computed value.
  always_comb begin
    res_z = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
    if (s2_nan) begin
      res_z = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
    end else if (s2_inf) begin
      res_z = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (s2_zero || is_uf) begin
      res_z = {s2_sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (is_of) begin
      res_z = {s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end
  end

`ifdef FP_MUL_PIPE_FLAGS_EN
  logic       finite_op;
  logic [3:0] res_flags;

  always_comb begin
    finite_op = ~s2_nan & ~s2_inf & ~s2_zero;
    res_flags = {s2_nan,
                 finite_op & is_of,
                 finite_op & is_uf,
                 finite_op & (s2_inexact | is_of | is_uf)};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      out_z     <= res_z;
      out_tag   <= s2_tag;
    end
  end

`ifdef FP_MUL_PIPE_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flags <= 4'b0000;
    end else if (!stall) begin
      out_flags <= res_flags;
    end
  end
`endif

endmodule
